// File: rtl/bit_deserializer.sv
// bit_deserializer
// Collects a valid-qualified serial bitstream into WIDTH-bit parallel words.
// A completed word is presented on deser_data_o with a one-cycle strobe on
// deser_data_val_o, one clock after the cycle carrying its last bit. Bits
// arriving in the cycle right after completion start the next word, so a
// continuous stream produces one strobe every WIDTH cycles.
module bit_deserializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_i,
    input  logic             data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic             deser_data_val_o,
    output logic [CNT_W-1:0] fill_cnt_o
);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] data_reg;
    logic             data_val_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_bit;

    // Shift direction is fixed at elaboration: MSB-first pushes new bits in at
    // [0] so the oldest bit ends up at [WIDTH-1]; LSB-first mirrors that.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[WIDTH-2:0], data_i};
        end else begin : g_lsb_first
            assign shift_next = {data_i, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    // The current valid bit is the final one of the word when WIDTH-1 bits
    // are already held.
    assign last_bit = data_val_i && (cnt_reg == CNT_W'(WIDTH - 1));

    // Accumulate valid bits, publish the word on completion, reset wins.
    // data_i is only ever sampled under data_val_i, so X on idle cycles
    // never reaches the stored word.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shift_reg    <= '0;
            data_reg     <= '0;
            data_val_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            data_val_reg <= 1'b0;
            if (data_val_i) begin
                shift_reg <= shift_next;
                if (last_bit) begin
                    data_reg     <= shift_next;
                    data_val_reg <= 1'b1;
                    cnt_reg      <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign deser_data_o     = data_reg;
    assign deser_data_val_o = data_val_reg;
    assign fill_cnt_o       = cnt_reg;

endmodule

// File: tb/tb_bit_deserializer.sv
// Testbench for bit_deserializer: one MSB-first and one LSB-first instance
// share the same stimulus; a bit-queue reference model predicts both.
module tb_bit_deserializer;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b1;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [W-1:0]  data_m, data_l;
    logic          val_m, val_l;
    logic [CW-1:0] cnt_m, cnt_l;

    always #5 clk_i = ~clk_i;

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
        .deser_data_o(data_m), .deser_data_val_o(val_m), .fill_cnt_o(cnt_m));

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
        .deser_data_o(data_l), .deser_data_val_o(val_l), .fill_cnt_o(cnt_l));

    int errors = 0;
    int checks = 0;
    int cycle_no = 0;
    int strobes = 0;
    int strobe_cycles[$];

    // Reference model: bits received since last completion, plus last words.
    bit           q[$];
    logic [W-1:0] exp_m = '0;
    logic [W-1:0] exp_l = '0;
    logic         exp_val = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic val, input logic din);
        if (rst) begin
            q.delete();
            exp_m = '0;
            exp_l = '0;
            exp_val = 1'b0;
        end else begin
            exp_val = 1'b0;
            if (val) begin
                q.push_back(din);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        exp_m[W-1-i] = q[i];
                        exp_l[i]     = q[i];
                    end
                    exp_val = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, compare both instances to model.
    task automatic step(input logic rst, input logic val, input logic din);
        srst_i = rst;
        data_val_i = val;
        data_i = din;
        @(posedge clk_i);
        #1;
        cycle_no++;
        model_update(rst, val, din);
        if (val_m) begin
            strobes++;
            strobe_cycles.push_back(cycle_no);
        end
        chk("msb_data", 64'(data_m), 64'(exp_m));
        chk("msb_val",  64'(val_m),  64'(exp_val));
        chk("msb_cnt",  64'(cnt_m),  64'(q.size()));
        chk("lsb_data", 64'(data_l), 64'(exp_l));
        chk("lsb_val",  64'(val_l),  64'(exp_val));
        chk("lsb_cnt",  64'(cnt_l),  64'(q.size()));
        $display("cyc %0d rst=%0b v=%0b d=%0b | m:%h/%0b/%0d l:%h/%0b/%0d",
                 cycle_no, rst, val, din, data_m, val_m, cnt_m, data_l, val_l, cnt_l);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, w[W-1-i]);
    endtask

    typedef struct {
        logic         rst;
        logic         val;
        logic         din;
        logic         exp_val;
        logic [4:0]   exp_cnt;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Reset with toggling valid, release, a few bits, reset again.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 16'h0000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 16'h0000};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 16'h0000};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst, tbl[i].val, tbl[i].din);
            chk("tbl_val",  64'(val_m),  64'(tbl[i].exp_val));
            chk("tbl_cnt",  64'(cnt_m),  64'(tbl[i].exp_cnt));
            chk("tbl_data", 64'(data_m), 64'(tbl[i].exp_data));
        end

        // MSB-first word on consecutive cycles.
        step(1'b0, 1'b0, 1'b0);
        strobes = 0;
        send_word(16'hA5C3);
        chk("msbword_strobes", 64'(strobes), 64'd1);
        chk("msbword_data", 64'(data_m), 64'h A5C3);
        chk("msbword_cnt", 64'(cnt_m), 64'd0);

        // Gapped word, random data during gaps.
        strobes = 0;
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b1, 16'hA5C3 >> (W - 1 - i));
            if (i == 2 || i == 6 || i == 11) step(1'b0, 1'b0, 1'($urandom));
        end
        chk("gap_strobes", 64'(strobes), 64'd1);
        chk("gap_data", 64'(data_m), 64'hA5C3);
        step(1'b0, 1'b0, 1'($urandom));
        chk("gap_hold_val", 64'(val_m), 64'd0);
        chk("gap_hold_data", 64'(data_m), 64'hA5C3);

        // Back-to-back words.
        strobe_cycles.delete();
        send_word(16'h0001);
        chk("b2b_w0", 64'(data_m), 64'h0001);
        send_word(16'h8000);
        chk("b2b_w1", 64'(data_m), 64'h8000);
        send_word(16'hFFFF);
        chk("b2b_w2", 64'(data_m), 64'hFFFF);
        chk("b2b_nstrobe", 64'(strobe_cycles.size()), 64'd3);
        if (strobe_cycles.size() == 3) begin
            chk("b2b_gap01", 64'(strobe_cycles[1] - strobe_cycles[0]), 64'd16);
            chk("b2b_gap12", 64'(strobe_cycles[2] - strobe_cycles[1]), 64'd16);
        end

        // LSB-first build: 1 then fifteen 0s.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i < W; i++) step(1'b0, 1'b1, 1'b0);
        chk("lsb_first_word", 64'(data_l), 64'h0001);
        chk("lsb_first_msbinst", 64'(data_m), 64'h8000);

        // Reset mid-word.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'($urandom));
        chk("mid_cnt9", 64'(cnt_m), 64'd9);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst_cnt", 64'(cnt_m), 64'd0);
        chk("mid_rst_data", 64'(data_m), 64'd0);
        strobes = 0;
        send_word(16'h1234);
        chk("mid_strobes", 64'(strobes), 64'd1);
        chk("mid_data", 64'(data_m), 64'h1234);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
